// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision FP adder back end.
// Mantissa layout: carry | hidden | fraction | guard | sticky.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam int MANT_W = FRAC_W + 4;
  localparam int EXPI_W = EXP_W + 2;

  localparam int CARRY  = FRAC_W + 3;
  localparam int HIDDEN = FRAC_W + 2;
  localparam int LSB    = 2;
  localparam int GUARD  = 1;
  localparam int STICKY = 0;

  localparam int EXP_MAX = (1 << EXP_W) - 1;

  localparam logic signed [EXPI_W-1:0] EXP_ONE   = EXPI_W'(1);
  localparam logic signed [EXPI_W-1:0] EXP_MAX_S = EXPI_W'(EXP_MAX);

  // Magnitude fields {exp, frac} for the special results
  localparam logic [EXP_W+FRAC_W-1:0] INF_MAG  = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  localparam logic [EXP_W+FRAC_W-1:0] ZERO_MAG = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fpState_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized mantissa; shared with the multiplier path.
// sigOut is {hidden, fraction} already re-normalized when rounding carries out.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mantIn,
  output logic [FRAC_W:0]   sigOut,
  output logic              carryOut,
  output logic              inexact
);

  logic              roundUp;
  logic [FRAC_W+1:0] sum;

  assign roundUp  = mantIn[GUARD] & (mantIn[STICKY] | mantIn[LSB]);
  assign inexact  = mantIn[GUARD] | mantIn[STICKY];
  assign sum      = {1'b0, mantIn[HIDDEN:LSB]} + {{(FRAC_W+1){1'b0}}, roundUp};
  assign carryOut = sum[FRAC_W+1];
  assign sigOut   = carryOut ? sum[FRAC_W+1:1] : sum[FRAC_W:0];

endmodule

// File: rtl/fp_normalize_round.sv
// Normalize (one bit per cycle), round-to-nearest-even and pack a binary32 result.
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// NORM  | one normalization shift per cycle, or flush on exponent floor
// ROUND | apply RNE, detect overflow, pack result
// DONE  | result presented, held until out_ready
module fp_normalize_round
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exponent,
  input  logic [MANT_W-1:0] in_mantissa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);

  fpState_t                  state;
  logic                      sign;
  logic signed [EXPI_W-1:0]  exponent;
  logic [MANT_W-1:0]         mant;

  logic [FRAC_W:0]           rndSig;
  logic                      rndCarry;
  logic                      rndInexact;
  logic signed [EXPI_W-1:0]  expRounded;

  fp_round_rne uRound (
    .mantIn   (mant),
    .sigOut   (rndSig),
    .carryOut (rndCarry),
    .inexact  (rndInexact)
  );

  assign expRounded = exponent + (rndCarry ? EXP_ONE : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sign          <= 1'b0;
      exponent      <= '0;
      mant          <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready      <= 1'b0;
            sign          <= in_sign;
            exponent      <= signed'({2'b00, in_exponent});
            mant          <= in_mantissa;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
            if (in_mantissa == '0) begin
              out_result <= {in_sign, ZERO_MAG};
              state      <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mant[CARRY]) begin
            // the bit shifted out folds into sticky
            mant     <= {1'b0, mant[MANT_W-1:2], mant[GUARD] | mant[STICKY]};
            exponent <= exponent + EXP_ONE;
          end else if (!mant[HIDDEN] && exponent > EXP_ONE) begin
            mant     <= {mant[MANT_W-2:0], 1'b0};
            exponent <= exponent - EXP_ONE;
          end else if (!mant[HIDDEN]) begin
            out_result    <= {sign, ZERO_MAG};
            out_underflow <= 1'b1;
            out_inexact   <= 1'b1;
            state         <= DONE;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (expRounded >= EXP_MAX_S) begin
            out_result   <= {sign, INF_MAG};
            out_overflow <= 1'b1;
            out_inexact  <= 1'b1;
          end else begin
            out_result  <= {sign, expRounded[EXP_W-1:0], rndSig[FRAC_W-1:0]};
            out_inexact <= rndInexact;
          end
          state <= DONE;
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed-vector bench for fp_normalize_round with hand-computed expected results.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [26:0] in_mantissa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  int passCnt = 0;
  int totalCnt = 0;

  fp_normalize_round dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exponent   (in_exponent),
    .in_mantissa   (in_mantissa),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    totalCnt++;
    if (obs === expd) passCnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expd);
  endtask

  // Called #1 after a rising edge; hold keeps out_ready low that many valid cycles.
  task automatic runOp(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                       input int expLat, input logic [31:0] expRes,
                       input logic ov, input logic uf, input logic ix, input int hold);
    int cycles;
    checkVal({tag, "_inready"}, {31'd0, in_ready}, 32'd1);
    in_valid    = 1'b1;
    in_sign     = s;
    in_exponent = e;
    in_mantissa = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (out_valid) break;
    end
    checkVal({tag, "_latency"}, 32'(cycles), 32'(expLat));
    checkVal({tag, "_result"}, out_result, expRes);
    checkVal({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, ov});
    checkVal({tag, "_unf"}, {31'd0, out_underflow}, {31'd0, uf});
    checkVal({tag, "_inx"}, {31'd0, out_inexact}, {31'd0, ix});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checkVal({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      checkVal({tag, "_hold_result"}, out_result, expRes);
      checkVal({tag, "_hold_inready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkVal({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    checkVal({tag, "_back_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_sign     = 1'b0;
    in_exponent = '0;
    in_mantissa = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_inready", {31'd0, in_ready}, 32'd1);
    checkVal("rst_outvalid", {31'd0, out_valid}, 32'd0);
    checkVal("rst_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp("one",      1'b0, 8'd127, 27'h2000000, 3,  32'h3F800000, 1'b0, 1'b0, 1'b0, 0);
    runOp("carry",    1'b0, 8'd127, 27'h4000000, 4,  32'h40000000, 1'b0, 1'b0, 1'b0, 0);
    runOp("ovf",      1'b0, 8'd254, 27'h4000000, 4,  32'h7F800000, 1'b1, 1'b0, 1'b1, 0);
    runOp("rnd_up",   1'b0, 8'd127, 27'h2000006, 3,  32'h3F800002, 1'b0, 1'b0, 1'b1, 0);
    runOp("rnd_tie",  1'b0, 8'd127, 27'h2000002, 3,  32'h3F800000, 1'b0, 1'b0, 1'b1, 0);
    runOp("rnd_carry",1'b0, 8'd127, 27'h3FFFFFE, 3,  32'h40000000, 1'b0, 1'b0, 1'b1, 0);
    runOp("cancel",   1'b0, 8'd127, 27'h0000004, 26, 32'h34000000, 1'b0, 1'b0, 1'b0, 0);
    runOp("unf",      1'b0, 8'd1,   27'h1000000, 2,  32'h00000000, 1'b0, 1'b1, 1'b1, 0);
    runOp("negzero",  1'b1, 8'd77,  27'h0000000, 1,  32'h80000000, 1'b0, 1'b0, 1'b0, 5);
    runOp("neg_half", 1'b1, 8'd126, 27'h2000000, 3,  32'hBF000000, 1'b0, 1'b0, 1'b0, 0);

    // Abort a long cancellation mid-normalization
    in_valid    = 1'b1;
    in_sign     = 1'b0;
    in_exponent = 8'd127;
    in_mantissa = 27'h0000004;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkVal("abort_outvalid", {31'd0, out_valid}, 32'd0);
    checkVal("abort_inready", {31'd0, in_ready}, 32'd1);
    checkVal("abort_result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runOp("after_rst", 1'b0, 8'd127, 27'h2000006, 3, 32'h3F800002, 1'b0, 1'b0, 1'b1, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Post-alignment stage of the single-precision FP adder. Consumes the 27-bit aligned/summed mantissa, with guard and sticky bits, produced after the align shifter and mantissa add.
- Normalizes iteratively, one bit per cycle, then rounds to nearest-even and packs an IEEE-754 binary32 result with flags.
- Sits between the mantissa adder and the FP register writeback; uses a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width
- FRAC_W, 23, fraction field width (the mantissa input is FRAC_W+4 bits)
- BIAS, 127, exponent bias (used only for documentation/asserts; packing uses the raw biased exponent)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  stage can accept; high only in IDLE
- in_sign  in  1  result sign
- in_exponent  in  EXP_W  biased exponent of the larger operand
- in_mantissa  in  FRAC_W+4  bit26 = add carry, bit25 = hidden, bits24:2 = fraction, bit1 = guard, bit0 = sticky
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  32  packed {sign, exp, frac}
- out_overflow  out  1  result overflowed to infinity
- out_underflow  out  1  result flushed to zero (exp underflow)
- out_inexact  out  1  guard or sticky was nonzero at rounding

Behaviour:
- Reset (async, rst_n low): state=IDLE, in_ready=1, out_valid=0, out_result=0, all flags 0, internal regs 0. Deassertion is synchronous to clk at the module boundary (handled upstream).
- Internal exponent is a signed EXP_W+2-bit register so that +1 and -1 steps cannot wrap.
- IDLE:
  - in_ready=1.
  - On in_valid, capture sign, exponent, and mantissa.
  - Mantissa==0 -> DONE with result {sign,0,0} and no flags.
  - Otherwise -> NORM.
- NORM (one action per cycle):
  - bit26=1: shift right 1, bit0 <= bit0|bit1 (sticky keeps the shifted-out bit), exp+1, stay in NORM.
  - Else bit25=0 and exp>1: shift left 1 (zero in at bit0), exp-1, stay in NORM.
  - Else bit25=0 and exp<=1: flush to zero -> DONE with result {sign,0,0}, underflow=1, inexact=1.
  - Else (normalized) -> ROUND.
- ROUND (1 cycle):
  - round_up = G & (S | LSB), where LSB=bit2.
  - mant[26:2] += round_up.
  - Carry into bit26: shift right 1 and exp+1.
  - inexact = G|S before rounding.
  - exp>=255 after this step -> result {sign,8'hFF,0}, overflow=1, inexact=1.
  - Otherwise result = {sign, exp[7:0], mant[24:2]}.
  - -> DONE.
- DONE:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid&out_ready -> IDLE; out_valid drops the next cycle.
  - No new input is accepted in the same cycle (in_ready=0 outside IDLE).
- Latency, accept edge to out_valid: n+3 cycles for n normalization shifts; 1 cycle for a zero mantissa; worst case n=25 (28 cycles).
- Bounds: left shifts are bounded by the exponent floor and by the mantissa width. A nonzero mantissa reaches bit25 within 25 shifts.
- in_valid while busy is ignored and must be held by the producer.
- Reset mid-operation aborts immediately; no partial result is emitted.

Decomposition:
- Shared package fp_pkg:
  - EXP_W, FRAC_W, BIAS
  - state enum {IDLE, NORM, ROUND, DONE}
  - EXP_MAX=255 and the infinity/zero pack constants
  - mantissa bit-index localparams (CARRY=26, HIDDEN=25, LSB=2, GUARD=1, STICKY=0)
- One natural sub-module: fp_round_rne (combinational; mantissa + G/S in, rounded mantissa + carry + inexact out). Reusable by the multiplier path.

Test Plan:
- sign0, exp127, mant 27'h2000000 -> out_result 32'h3F800000 at accept+3, no flags.
- sign0, exp127, mant 27'h4000000 (carry) -> 32'h40000000 at accept+4; same mant with exp254 -> 32'h7F800000, overflow=1, inexact=1.
- Rounding, exp127:
  - 27'h2000006 -> 32'h3F800002, inexact=1.
  - 27'h2000002 (tie, even) -> 32'h3F800000, inexact=1.
  - 27'h3FFFFFE (all ones, round carry) -> 32'h40000000, inexact=1.
- Cancellation: exp127, mant 27'h0000004 -> 23 left shifts -> 32'h34000000 at accept+26; exp1, mant 27'h1000000 -> 32'h00000000, underflow=1.
- Zero mantissa, sign1 -> 32'h80000000 at accept+1; out_ready held low 5 cycles -> out_valid and result stable, in_ready=0 throughout.
- Assert rst_n low during NORM of the cancellation case -> out_valid=0 and in_ready=1 immediately; the next operand is processed correctly.
